// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite motion controller.
package pacman_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        STOP = 1'b0,
        MOVE = 1'b1
    } state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;

    localparam int TILE      = 32;
    localparam int TILE_BITS = $clog2(TILE);

    function automatic dir_t opposite(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame clock into the Clk domain and emits a one-cycle
// pulse for each of its rising edges.
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_clk_i,
    output logic tick_o
);

    // [0],[1] form the synchronizer; [2] holds the previous synchronized level.
    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk_i};
        end
    end

    assign tick_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pacman_motion.sv
// Tile-aligned Pac-Man motion: queued turns, stop at walls, instant reversal,
// one STEP per frame tick. Position registers feed the downstream wall lookup.
module pacman_motion
    import pacman_pkg::*;
#(
    parameter int START_X = 35,
    parameter int START_Y = 35,
    parameter int OFFSET  = 3,
    parameter int STEP    = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       is_wall_up,
    input  logic       is_wall_down,
    input  logic       is_wall_left,
    input  logic       is_wall_right,
    output logic [9:0] Ball_X_Pos_out,
    output logic [9:0] Ball_Y_Pos_out,
    output logic [1:0] dir,
    output logic       moving
);

    localparam logic [TILE_BITS-1:0] OFF_BITS = TILE_BITS'(OFFSET);
    localparam logic [9:0]           STEP_V   = 10'(STEP);

    logic [9:0] x_q, y_q;
    dir_t       dir_q, pend_dir_q;
    logic       pend_valid_q;
    state_t     state_q;

    logic       tick;
    logic       key_valid;
    dir_t       key_dir;
    logic [3:0] wall_vec;
    logic       aligned, reverse, take_pend, stop_now, do_step;
    dir_t       step_dir;

    frame_tick_sync u_tick (
        .clk_i      (Clk),
        .rst_ni     (Reset_n),
        .frame_clk_i(frame_clk),
        .tick_o     (tick)
    );

    always_comb begin
        key_valid = 1'b1;
        key_dir   = UP;
        case (keycode)
            KEY_W:   key_dir = UP;
            KEY_S:   key_dir = DOWN;
            KEY_A:   key_dir = LEFT;
            KEY_D:   key_dir = RIGHT;
            default: key_valid = 1'b0;
        endcase
    end

    // Indexed by dir_t encoding so a direction selects its own wall flag.
    assign wall_vec = {is_wall_right, is_wall_left, is_wall_down, is_wall_up};
    assign aligned  = (x_q[TILE_BITS-1:0] == OFF_BITS) && (y_q[TILE_BITS-1:0] == OFF_BITS);

    // Reversal skips the wall check: the corridor just travelled is known open.
    assign reverse   = (state_q == MOVE) && pend_valid_q && (pend_dir_q == opposite(dir_q));
    assign take_pend = tick && (reverse || (aligned && pend_valid_q && !wall_vec[pend_dir_q]));
    assign stop_now  = tick && (state_q == MOVE) && !take_pend && aligned && wall_vec[dir_q];
    assign do_step   = take_pend || (tick && (state_q == MOVE) && !stop_now);
    assign step_dir  = take_pend ? pend_dir_q : dir_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_q          <= 10'(START_X);
            y_q          <= 10'(START_Y);
            dir_q        <= RIGHT;
            pend_dir_q   <= UP;
            pend_valid_q <= 1'b0;
            state_q      <= STOP;
        end else begin
            if (take_pend) begin
                dir_q   <= pend_dir_q;
                state_q <= MOVE;
            end else if (stop_now) begin
                state_q <= STOP;
            end

            if (do_step) begin
                case (step_dir)
                    UP:      y_q <= y_q - STEP_V;
                    DOWN:    y_q <= y_q + STEP_V;
                    LEFT:    x_q <= x_q - STEP_V;
                    default: x_q <= x_q + STEP_V;
                endcase
            end

            // A key arriving with a consuming tick wins; the tick used the old request.
            if (key_valid) begin
                pend_valid_q <= 1'b1;
                pend_dir_q   <= key_dir;
            end else if (take_pend) begin
                pend_valid_q <= 1'b0;
            end
        end
    end

    assign Ball_X_Pos_out = x_q;
    assign Ball_Y_Pos_out = y_q;
    assign dir            = dir_q;
    assign moving         = (state_q == MOVE);

endmodule

// File: tb/tb_pacman_motion.sv
// Bench for pacman_motion: a maze wall stage, directed scenarios and random
// key/frame activity, all checked against a behavioural motion model.
module tb_pacman_motion;

    logic       Clk;
    logic       Reset_n;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       is_wall_up, is_wall_down, is_wall_left, is_wall_right;
    logic [9:0] Ball_X_Pos_out, Ball_Y_Pos_out;
    logic [1:0] dir;
    logic       moving;

    int n_checks = 0;
    int n_errors = 0;

    logic [22:0] exp_q[$];

    pacman_motion dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_clk     (frame_clk),
        .keycode       (keycode),
        .is_wall_up    (is_wall_up),
        .is_wall_down  (is_wall_down),
        .is_wall_left  (is_wall_left),
        .is_wall_right (is_wall_right),
        .Ball_X_Pos_out(Ball_X_Pos_out),
        .Ball_Y_Pos_out(Ball_Y_Pos_out),
        .dir           (dir),
        .moving        (moving)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic do_reset();
        @(negedge Clk);
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // ---------------- maze / wall stage ----------------
    // Tiles are 32 px; rows/cols 0 and >=10 are border. Row 1 is open for
    // cols 1..4 only, row 2 opens only at col 4, deeper rows form a grid.
    function automatic bit maze_wall(input int r, input int c);
        if (r <= 0 || c <= 0 || r >= 10 || c >= 10) return 1'b1;
        if (r == 1) return (c >= 5);
        if (r == 2) return (c != 4);
        return ((r % 2) == 0) && ((c % 2) == 0);
    endfunction

    function automatic bit wall_toward(input int x, input int y, input int d);
        int r, c;
        r = y / 32;
        c = x / 32;
        case (d)
            0:       return maze_wall(r - 1, c);
            1:       return maze_wall(r + 1, c);
            2:       return maze_wall(r, c - 1);
            default: return maze_wall(r, c + 1);
        endcase
    endfunction

    always_comb begin
        is_wall_up    = 1'b1;
        is_wall_down  = 1'b1;
        is_wall_left  = 1'b1;
        is_wall_right = 1'b1;
        if ((int'(Ball_X_Pos_out) % 32 == 3) && (int'(Ball_Y_Pos_out) % 32 == 3)) begin
            is_wall_up    = wall_toward(int'(Ball_X_Pos_out), int'(Ball_Y_Pos_out), 0);
            is_wall_down  = wall_toward(int'(Ball_X_Pos_out), int'(Ball_Y_Pos_out), 1);
            is_wall_left  = wall_toward(int'(Ball_X_Pos_out), int'(Ball_Y_Pos_out), 2);
            is_wall_right = wall_toward(int'(Ball_X_Pos_out), int'(Ball_Y_Pos_out), 3);
        end
    end

    // ---------------- behavioural model ----------------
    int mx, my, mdir, mpd;
    bit mmov, mpv;
    bit h1, h2, h3;
    bit m_tick, m_al, m_take;
    int m_key;
    int opp_tbl[4] = '{1, 0, 3, 2};

    function automatic int key_to_dir(input logic [7:0] k);
        case (k)
            8'h1A:   return 0;
            8'h16:   return 1;
            8'h04:   return 2;
            8'h07:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_step(input int d);
        case (d)
            0:       my = my - 1;
            1:       my = my + 1;
            2:       mx = mx - 1;
            default: mx = mx + 1;
        endcase
    endtask

    // A frame_clk rise seen at edge m-2 (low at m-3) moves the sprite at edge m.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mx = 35; my = 35; mdir = 3; mmov = 0; mpv = 0; mpd = 0;
            h1 = 0; h2 = 0; h3 = 0;
            exp_q.delete();
        end else begin
            m_tick = h2 && !h3;
            h3 = h2; h2 = h1; h1 = frame_clk;
            if (m_tick) begin
                m_al   = (mx % 32 == 3) && (my % 32 == 3);
                m_take = 0;
                if (mmov && mpv && mpd == opp_tbl[mdir]) m_take = 1;
                else if (m_al && mpv && !wall_toward(mx, my, mpd)) m_take = 1;
                if (m_take) begin
                    mdir = mpd; mpv = 0; mmov = 1;
                    model_step(mdir);
                end else if (mmov) begin
                    if (m_al && wall_toward(mx, my, mdir)) mmov = 0;
                    else model_step(mdir);
                end
            end
            m_key = key_to_dir(keycode);
            if (m_key >= 0) begin
                mpv = 1;
                mpd = m_key;
            end
            exp_q.push_back({10'(mx), 10'(my), 2'(mdir), mmov});
        end
    end

    // ---------------- scoreboard ----------------
    logic [22:0] sb_exp, sb_act;
    always @(negedge Clk) begin
        if (Reset_n && exp_q.size() != 0) begin
            sb_exp = exp_q.pop_front();
            sb_act = {Ball_X_Pos_out, Ball_Y_Pos_out, dir, moving};
            n_checks++;
            if (sb_act !== sb_exp) begin
                n_errors++;
                $display("FAIL model_cmp t=%0t actual x=%0d y=%0d dir=%0d mov=%0d required x=%0d y=%0d dir=%0d mov=%0d",
                         $time, sb_act[22:13], sb_act[12:3], sb_act[2:1], sb_act[0],
                         sb_exp[22:13], sb_exp[12:3], sb_exp[2:1], sb_exp[0]);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_out(input string name, input int x, input int y, input int d, input int mv);
        check({name, "_x"}, int'(Ball_X_Pos_out), x);
        check({name, "_y"}, int'(Ball_Y_Pos_out), y);
        check({name, "_dir"}, int'(dir), d);
        check({name, "_mov"}, int'(moving), mv);
    endtask

    // ---------------- drivers ----------------
    task automatic do_tick(input int hi, input int lo);
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (hi) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (lo) @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(2, 3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;

        do_reset();
        check_out("reset", 35, 35, 3, 0);
        ticks(3);
        check_out("idle_ticks", 35, 35, 3, 0);

        keycode = 8'h1A;
        ticks(10);
        check_out("up_blocked", 35, 35, 3, 0);
        keycode = 8'h07;
        ticks(1);
        check_out("start_right", 36, 35, 3, 1);
        check("start_right_model_x", mx, 36);

        ticks(95);
        check_out("reach_131", 131, 35, 3, 1);
        check("reach_131_model_x", mx, 131);
        ticks(1);
        check_out("stop_wall", 131, 35, 3, 0);
        check("stop_wall_model_mov", int'(mmov), 0);

        do_reset();
        keycode = 8'h07;
        ticks(15);
        check_out("at_50", 50, 35, 3, 1);
        keycode = 8'h16;
        ticks(81);
        check_out("queued_down_131", 131, 35, 3, 1);
        ticks(1);
        check_out("turn_down", 131, 36, 1, 1);
        check("turn_down_model_y", my, 36);

        do_reset();
        keycode = 8'h07;
        ticks(15);
        keycode = 8'h04;
        ticks(1);
        check_out("reverse_left", 49, 35, 2, 1);

        do_reset();
        keycode = 8'h07;
        ticks(45);
        check_out("at_80", 80, 35, 3, 1);
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1 check_out("async_reset", 35, 35, 3, 0);
        check("async_reset_model_x", mx, 35);
        @(negedge Clk);
        keycode = 8'h00;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_out("after_async_reset", 35, 35, 3, 0);

        // Random key presses and frame-clock activity, checked every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 5))
                    0:       keycode = 8'h00;
                    1:       keycode = 8'h1A;
                    2:       keycode = 8'h16;
                    3:       keycode = 8'h04;
                    4:       keycode = 8'h07;
                    default: keycode = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
        end
        frame_clk = 1'b0;
        keycode   = 8'h00;
        repeat (5) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
